tcdm_stream_reader: RTL and testbench
=====================================

Name: tcdm_stream_reader

Overview:
- Strided TCDM read master that feeds a TCDM target (memory or interconnect port) and converts its responses into a valid/ready word stream for an accelerator datapath.
- Sits directly upstream of the TCDM memory model in the testbench and of the real TCDM in the cluster.
- Uses credit-based issue, so the response FIFO never overflows regardless of grant stalls or stream back-pressure.

Parameters:
- FIFO_DEPTH, 4, response FIFO entries; also caps in-flight reads (power of 2, >=2)
- CNT_WIDTH, 16, width of transfer length and word index counters

Ports:
- clk_i  in  1  clock, all state updates on rising edge
- rst_ni  in  1  asynchronous active-low reset
- clear_i  in  1  synchronous soft clear, flushes all state to reset values
- start_i  in  1  start pulse; sampled only in IDLE
- base_addr_i  in  32  byte address of first word
- stride_i  in  32  byte increment between words (two's complement)
- len_i  in  CNT_WIDTH  number of words to read
- busy_o  out  1  high in ISSUE and DRAIN
- done_o  out  1  one-cycle pulse at end of transfer
- tcdm_req_o  out  1  TCDM request
- tcdm_gnt_i  in  1  TCDM grant
- tcdm_add_o  out  32  TCDM byte address
- tcdm_wen_o  out  1  constant 1 (read)
- tcdm_be_o  out  4  constant 4'hF
- tcdm_data_o  out  32  constant 0
- tcdm_r_data_i  in  32  response data
- tcdm_r_valid_i  in  1  response valid, one per granted request, in order
- stream_data_o  out  32  FIFO head word
- stream_valid_o  out  1  FIFO non-empty
- stream_ready_i  in  1  consumer accepts head

Behaviour:
- Reset (rst_ni low, async) and clear_i (sync): FSM=IDLE; busy_o, done_o, tcdm_req_o, stream_valid_o = 0; tcdm_add_o = 0; counters and FIFO empty.
- FSM states IDLE, ISSUE, DRAIN.
- IDLE, start_i=1, len_i>0: latch base, stride, len; addr register = base; idx=0; -> ISSUE.
- IDLE, start_i=1, len_i=0: done_o pulses the next cycle; FSM stays IDLE; no TCDM traffic.
- start_i while busy: ignored.
- Credit: credit = FIFO_DEPTH - fifo_count - outstanding.
- ISSUE: tcdm_req_o = (credit>0). Once asserted, req and add are held stable until gnt; credit cannot drop while req is pending.
- On req&gnt: idx++, outstanding++, addr += stride (32-bit wrap). If the new idx==len, go to DRAIN; req drops in that same next cycle.
- tcdm_r_valid_i: push tcdm_r_data_i into the FIFO; outstanding--.
- Simultaneous grant and r_valid: outstanding unchanged.
- r_valid with outstanding==0 (stray response, or response after clear): data dropped, no state change.
- DRAIN: when outstanding==0 and the FIFO is empty (last word popped), done_o pulses 1 cycle and FSM -> IDLE. done_o coincides with the cycle after the last pop.
- FIFO: stream_valid_o = !empty; pop on valid&ready; push and pop in the same cycle are allowed at any level, including full.
- FIFO overflow is impossible by construction. A simulation assertion flags push while full and pop while empty.
- Stream order equals address order; no reordering.

Optional Feature:
- Macro TCDM_STREAM_READER_PERF_EN.
- Defined: adds outputs perf_stall_o[31:0] and perf_bp_o[31:0].
  - perf_stall_o counts cycles with req&!gnt.
  - perf_bp_o counts cycles with stream_valid&!stream_ready.
  - Both cleared on start accept, reset and clear_i; they saturate at 2^32-1.
- Not defined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- base=0x100, stride=4, len=8, gnt always 1, ready always 1:
  - addresses 0x100..0x11C issued on consecutive cycles;
  - stream yields mem[0x100..0x11C] in order;
  - done_o exactly once.
- Same transfer with stream_ready_i=0 for 20 cycles:
  - at most 4 requests granted, then req_o=0;
  - after ready rises, all 8 words delivered, no loss or duplicate.
- Random grant stalls (probability 0.5) with len=16, stride=-8 from base 0x400:
  - addresses decrease by 8 each grant;
  - addr held stable while req&!gnt;
  - data in order.
- len_i=0 start -> done_o high one cycle later; req_o never asserted; busy_o stays 0.
- Reset and clear mid-transfer:
  - rst_ni low mid-ISSUE with 2 reads in flight -> all outputs 0 immediately; the late r_valid is ignored; a new start with len=4 completes correctly.
  - Same check with clear_i instead of reset.
- Stray r_valid in IDLE -> stream_valid_o stays 0; with PERF_EN, perf_stall_o equals the measured req&!gnt cycle count of the preceding transfer.

Source files
------------

// File: rtl/tcdm_stream_reader_if.sv
// Bundle of the TCDM request/response channel and the outgoing word stream
// seen by tcdm_stream_reader; master is the reader, slave is its environment.
interface tcdm_stream_reader_if;
  logic        tcdm_req;
  logic        tcdm_gnt;
  logic [31:0] tcdm_add;
  logic        tcdm_wen;
  logic [3:0]  tcdm_be;
  logic [31:0] tcdm_data;
  logic [31:0] tcdm_r_data;
  logic        tcdm_r_valid;
  logic [31:0] stream_data;
  logic        stream_valid;
  logic        stream_ready;

  modport master (
    output tcdm_req, tcdm_add, tcdm_wen, tcdm_be, tcdm_data,
    output stream_data, stream_valid,
    input  tcdm_gnt, tcdm_r_data, tcdm_r_valid, stream_ready
  );

  modport slave (
    input  tcdm_req, tcdm_add, tcdm_wen, tcdm_be, tcdm_data,
    input  stream_data, stream_valid,
    output tcdm_gnt, tcdm_r_data, tcdm_r_valid, stream_ready
  );
endinterface

// File: rtl/tcdm_stream_reader.sv
// Strided TCDM read master with credit-limited issue and a response FIFO.
// Optional cycle counters enabled by TCDM_STREAM_READER_PERF_EN.
module tcdm_stream_reader #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic                 start_i,
  input  logic [31:0]          base_addr_i,
  input  logic [31:0]          stride_i,
  input  logic [CNT_WIDTH-1:0] len_i,
  output logic                 busy_o,
  output logic                 done_o,
  tcdm_stream_reader_if.master bus
`ifdef TCDM_STREAM_READER_PERF_EN
  ,
  output logic [31:0]          perf_stall_o,
  output logic [31:0]          perf_bp_o
`endif
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned OCC_W = PTR_W + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic [OCC_W:0]   DEPTH_C   = (OCC_W+1)'(FIFO_DEPTH);
  localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(FIFO_DEPTH);

  logic [1:0]           state_q, state_d;
  logic [31:0]          addr_q, addr_d;
  logic [31:0]          stride_q, stride_d;
  logic [CNT_WIDTH-1:0] len_q, len_d;
  logic [CNT_WIDTH-1:0] idx_q, idx_d;
  logic [OCC_W-1:0]     outst_q, outst_d;
  logic [OCC_W-1:0]     fifo_cnt_q, fifo_cnt_d;
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic                 done_q, done_d;
  logic [31:0]          fifo_mem_q [FIFO_DEPTH];

  logic [OCC_W:0]       credit;
  logic                 req;
  logic                 gnt_fire;
  logic                 push;
  logic                 pop;
  logic                 fifo_empty;
  logic                 start_acc;

  // Words already buffered plus words still in flight never exceed the FIFO
  // size; a grant is the only event that lowers credit, so a pending
  // request cannot lose its credit before it is granted.
  assign credit     = DEPTH_C - {1'b0, fifo_cnt_q} - {1'b0, outst_q};
  assign req        = (state_q == ST_ISSUE) && (credit != '0);
  assign gnt_fire   = req && bus.tcdm_gnt;
  assign push       = bus.tcdm_r_valid && (outst_q != '0);
  assign fifo_empty = (fifo_cnt_q == '0);
  assign pop        = !fifo_empty && bus.stream_ready;
  assign start_acc  = (state_q == ST_IDLE) && start_i;

  assign bus.tcdm_req     = req;
  assign bus.tcdm_add     = addr_q;
  assign bus.tcdm_wen     = 1'b1;
  assign bus.tcdm_be      = 4'hF;
  assign bus.tcdm_data    = 32'h0;
  assign bus.stream_data  = fifo_mem_q[rd_ptr_q];
  assign bus.stream_valid = !fifo_empty;

  assign busy_o = (state_q != ST_IDLE);
  assign done_o = done_q;

  always_comb begin
    outst_d = outst_q;
    case ({gnt_fire, push})
      2'b10:   outst_d = outst_q + OCC_W'(1);
      2'b01:   outst_d = outst_q - OCC_W'(1);
      default: outst_d = outst_q;
    endcase
  end

  always_comb begin
    fifo_cnt_d = fifo_cnt_q;
    case ({push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + OCC_W'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - OCC_W'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    stride_d = stride_q;
    len_d    = len_q;
    idx_d    = idx_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          if (len_i != '0) begin
            addr_d   = base_addr_i;
            stride_d = stride_i;
            len_d    = len_i;
            idx_d    = '0;
            state_d  = ST_ISSUE;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        if (gnt_fire) begin
          idx_d  = idx_q + CNT_WIDTH'(1);
          addr_d = addr_q + stride_q;
          if (idx_d == len_q) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        // Look at next-cycle occupancy so done lands right after the last pop.
        if ((outst_d == '0) && (fifo_cnt_d == '0)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      stride_q   <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      outst_q    <= '0;
      fifo_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      done_q     <= 1'b0;
    end else if (clear_i) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      stride_q   <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      outst_q    <= '0;
      fifo_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      stride_q   <= stride_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      outst_q    <= outst_d;
      fifo_cnt_q <= fifo_cnt_d;
      done_q     <= done_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
    end
  end

  // Storage carries no reset; the occupancy counter alone defines validity.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= bus.tcdm_r_data;
    end
  end

`ifdef TCDM_STREAM_READER_PERF_EN
  logic [31:0] perf_stall_q, perf_bp_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_stall_q <= '0;
      perf_bp_q    <= '0;
    end else if (clear_i || start_acc) begin
      perf_stall_q <= '0;
      perf_bp_q    <= '0;
    end else begin
      if (req && !bus.tcdm_gnt && (perf_stall_q != 32'hFFFF_FFFF)) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
      if (!fifo_empty && !bus.stream_ready && (perf_bp_q != 32'hFFFF_FFFF)) begin
        perf_bp_q <= perf_bp_q + 32'd1;
      end
    end
  end

  assign perf_stall_o = perf_stall_q;
  assign perf_bp_o    = perf_bp_q;
`else
  logic unused_start_acc;
  assign unused_start_acc = start_acc;
`endif

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (rst_ni && !clear_i) begin
      assert (!(push && (fifo_cnt_q == DEPTH_OCC) && !pop))
        else $error("tcdm_stream_reader: push into full FIFO");
      assert (!(pop && fifo_empty))
        else $error("tcdm_stream_reader: pop from empty FIFO");
    end
  end
`endif

endmodule

// File: tb/tb_tcdm_stream_reader.sv
// Scoreboard bench for tcdm_stream_reader: a 2-cycle-latency memory model,
// expected addresses/words queued at start and checked on grant/pop.
`timescale 1ns/1ps
module tb_tcdm_stream_reader;
  localparam int FIFO_DEPTH = 4;
  localparam int CNT_WIDTH  = 16;

  logic                 clk_i = 1'b0;
  logic                 rst_ni = 1'b0;
  logic                 clear_i = 1'b0;
  logic                 start_i = 1'b0;
  logic [31:0]          base_addr_i = '0;
  logic [31:0]          stride_i = '0;
  logic [CNT_WIDTH-1:0] len_i = '0;
  logic                 busy_o;
  logic                 done_o;
`ifdef TCDM_STREAM_READER_PERF_EN
  logic [31:0]          perf_stall_o;
  logic [31:0]          perf_bp_o;
`endif

  tcdm_stream_reader_if bus();

  tcdm_stream_reader #(.FIFO_DEPTH(FIFO_DEPTH), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clear_i     (clear_i),
    .start_i     (start_i),
    .base_addr_i (base_addr_i),
    .stride_i    (stride_i),
    .len_i       (len_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .bus         (bus)
`ifdef TCDM_STREAM_READER_PERF_EN
    ,
    .perf_stall_o(perf_stall_o),
    .perf_bp_o   (perf_bp_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h5A5A_0000;
  endfunction

  // Memory model and environment drivers
  logic        gnt_q = 1'b1;
  logic        gnt_rand = 1'b0;
  logic        ready = 1'b1;
  logic        stray = 1'b0;
  logic [1:0]  rv_pipe = '0;
  logic [31:0] rd_pipe0 = '0;
  logic [31:0] rd_pipe1 = '0;

  assign bus.tcdm_gnt     = gnt_q;
  assign bus.stream_ready = ready;
  assign bus.tcdm_r_valid = rv_pipe[1] | stray;
  assign bus.tcdm_r_data  = stray ? 32'hDEAD_BEEF : rd_pipe1;

  always @(posedge clk_i) begin
    rv_pipe  <= {rv_pipe[0], bus.tcdm_req & bus.tcdm_gnt};
    rd_pipe0 <= mdata(bus.tcdm_add);
    rd_pipe1 <= rd_pipe0;
  end

  always @(posedge clk_i) begin
    #1;
    gnt_q = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Scoreboard and checking
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, act, exp);
    end
  endtask

  int          cyc = 0;
  int          grant_cnt = 0, grant_base = 0;
  int          first_grant_cyc = 0, last_grant_cyc = 0;
  int          stall_total = 0, stall_base = 0;
  int          bp_total = 0, bp_base = 0;
  int          done_cnt = 0, done_base = 0;
  int          done_cyc = 0, last_pop_cyc = 0;
  logic        hold_pending = 1'b0;
  logic [31:0] hold_add = '0;

  always @(negedge clk_i) begin
    cyc++;
    if (!rst_ni) begin
      hold_pending = 1'b0;
    end else begin
      if (hold_pending) begin
        check("hold_req", 32'(bus.tcdm_req), 32'd1);
        check("hold_add", bus.tcdm_add, hold_add);
      end
      hold_pending = bus.tcdm_req && !bus.tcdm_gnt && !clear_i;
      hold_add     = bus.tcdm_add;
      if (bus.tcdm_req && bus.tcdm_gnt) begin
        if (grant_cnt == grant_base) first_grant_cyc = cyc;
        last_grant_cyc = cyc;
        grant_cnt++;
        if (exp_addr_q.size() == 0) check("extra_grant", bus.tcdm_add, 32'hFFFF_FFFF);
        else check("grant_addr", bus.tcdm_add, exp_addr_q.pop_front());
      end
      if (bus.tcdm_req && !bus.tcdm_gnt) stall_total++;
      if (bus.stream_valid && !bus.stream_ready) bp_total++;
      if (bus.stream_valid && bus.stream_ready) begin
        last_pop_cyc = cyc;
        $display("pop data=0x%08h", bus.stream_data);
        if (exp_data_q.size() == 0) check("extra_word", bus.stream_data, 32'hFFFF_FFFF);
        else check("stream_data", bus.stream_data, exp_data_q.pop_front());
      end
      if (done_o) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic start_xfer(input logic [31:0] base, input logic [31:0] stride,
                            input logic [CNT_WIDTH-1:0] len);
    logic [31:0] a;
    @(posedge clk_i); #1;
    start_i = 1'b1; base_addr_i = base; stride_i = stride; len_i = len;
    for (int i = 0; i < int'(len); i++) begin
      a = base + 32'(i) * stride;
      exp_addr_q.push_back(a);
      exp_data_q.push_back(mdata(a));
    end
    grant_base = grant_cnt; stall_base = stall_total;
    bp_base = bp_total; done_base = done_cnt;
    $display("start base=0x%08h stride=0x%08h len=%0d", base, stride, len);
    @(posedge clk_i); #1;
    start_i = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int c = 0; c < 2000 && done_cnt == done_base; c++) @(negedge clk_i);
    if (done_cnt == done_base) check({tag, "_done_timeout"}, 32'd0, 32'd1);
    repeat (4) @(negedge clk_i);
    check({tag, "_done_once"}, 32'(done_cnt - done_base), 32'd1);
    check({tag, "_done_after_pop"}, 32'(done_cyc - last_pop_cyc), 32'd1);
    check({tag, "_sb_data_left"}, 32'(exp_data_q.size()), 32'd0);
    check({tag, "_sb_addr_left"}, 32'(exp_addr_q.size()), 32'd0);
    check({tag, "_busy_idle"}, 32'(busy_o), 32'd0);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"},  32'(busy_o), 32'd0);
    check({tag, "_done"},  32'(done_o), 32'd0);
    check({tag, "_req"},   32'(bus.tcdm_req), 32'd0);
    check({tag, "_valid"}, 32'(bus.stream_valid), 32'd0);
    check({tag, "_add"},   bus.tcdm_add, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check_quiet("reset");
    @(posedge clk_i); #1;
    rst_ni = 1'b1;

    // Contiguous burst, no stalls
    start_xfer(32'h100, 32'd4, 16'd8);
    wait_done("t1");
    check("t1_grant_span", 32'(last_grant_cyc - first_grant_cyc), 32'd7);
`ifdef TCDM_STREAM_READER_PERF_EN
    check("t1_perf_stall", perf_stall_o, 32'd0);
`endif

    // Consumer stalled for 20 cycles: credit caps requests at FIFO_DEPTH
    ready = 1'b0;
    start_xfer(32'h100, 32'd4, 16'd8);
    repeat (20) @(negedge clk_i);
    check("t2_grants_le_depth", 32'(grant_cnt - grant_base <= FIFO_DEPTH), 32'd1);
    check("t2_req_low", 32'(bus.tcdm_req), 32'd0);
    check("t2_valid_high", 32'(bus.stream_valid), 32'd1);
    @(posedge clk_i); #1;
    ready = 1'b1;
    wait_done("t2");
`ifdef TCDM_STREAM_READER_PERF_EN
    check("t2_perf_bp", perf_bp_o, 32'(bp_total - bp_base));
`endif

    // Random grant stalls, negative stride
    gnt_rand = 1'b1;
    start_xfer(32'h400, 32'hFFFF_FFF8, 16'd16);
    wait_done("t3");
    gnt_rand = 1'b0;

    // Stray response while idle must be dropped
    @(posedge clk_i); #1;
    stray = 1'b1;
    @(posedge clk_i); #1;
    stray = 1'b0;
    repeat (3) @(negedge clk_i);
    check("stray_valid", 32'(bus.stream_valid), 32'd0);
`ifdef TCDM_STREAM_READER_PERF_EN
    check("t3_perf_stall", perf_stall_o, 32'(stall_total - stall_base));
`endif

    // Zero-length start
    @(posedge clk_i); #1;
    start_i = 1'b1; len_i = '0; done_base = done_cnt;
    $display("start len=0");
    @(negedge clk_i);
    check("len0_done_early", 32'(done_o), 32'd0);
    @(posedge clk_i); #1;
    start_i = 1'b0;
    @(negedge clk_i);
    check("len0_done", 32'(done_o), 32'd1);
    check("len0_busy", 32'(busy_o), 32'd0);
    check("len0_req", 32'(bus.tcdm_req), 32'd0);
    @(negedge clk_i);
    check("len0_done_pulse", 32'(done_o), 32'd0);
    check("len0_req2", 32'(bus.tcdm_req), 32'd0);

    // Async reset with two reads in flight
    start_xfer(32'h200, 32'd4, 16'd8);
    repeat (2) @(posedge clk_i); #1;
    rst_ni = 1'b0;
    #1;
    check_quiet("mid_rst");
    exp_addr_q.delete(); exp_data_q.delete();
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    repeat (4) begin
      @(negedge clk_i);
      check("post_rst_valid", 32'(bus.stream_valid), 32'd0);
    end
    start_xfer(32'h300, 32'd4, 16'd4);
    wait_done("t5");

    // Synchronous clear with reads in flight
    start_xfer(32'h500, 32'd4, 16'd8);
    repeat (2) @(posedge clk_i); #1;
    clear_i = 1'b1;
    @(posedge clk_i); #1;
    check_quiet("mid_clr");
    exp_addr_q.delete(); exp_data_q.delete();
    clear_i = 1'b0;
    repeat (4) begin
      @(negedge clk_i);
      check("post_clr_valid", 32'(bus.stream_valid), 32'd0);
    end
    start_xfer(32'h600, 32'd4, 16'd4);
    wait_done("t6");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
